// File: rtl/nios_core_irq_pkg.sv
// Shared constants for the Nios interrupt aggregator: register addresses and VECTOR layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package nios_core_irq_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ENSET   = 3'd4;
  localparam logic [2:0] ADDR_ENCLR   = 3'd5;
  localparam logic [2:0] ADDR_VECTOR  = 3'd6;
  localparam logic [2:0] ADDR_SWTRIG  = 3'd7;

  localparam int VECTOR_VALID_BIT = 15;
  localparam int VECTOR_IDX_W     = 4;

endpackage

// File: rtl/nios_core_irq_ctrl_if.sv
// Avalon-MM slave bus (16-bit data, 3-bit word address) for the interrupt aggregator.
// Latency: reads return one clock after the address is presented.
// Backpressure: none; the slave accepts every cycle (no waitrequest).
interface nios_core_irq_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_core_irq_sync.sv
// Synchronizes asynchronous irq lines and flags rising edges of the synchronized value.
// Latency: s valid STAGES clocks after irq_in; rise is high for the one cycle s first goes high.
// Backpressure: none.
module nios_core_irq_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] s,
  output logic [W-1:0] rise
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             s_d;

  // Metastability chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      s_d    <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/nios_core_irq_ctrl.sv
// Interrupt aggregator: per-source mask, level/edge capture, software trigger, priority vector.
// Latency: irq_in to irq_out is SYNC_STAGES+2 clocks; register reads return after one clock.
// Backpressure: none; every bus cycle is accepted.
module nios_core_irq_ctrl
  import nios_core_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  nios_core_irq_ctrl_if.slave bus,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] s, rise;
  logic [NUM_IRQ-1:0] enable, mode, pending;
  logic [NUM_IRQ-1:0] wd, w1c, swtrig, active;
  logic               wr;
  logic [VECTOR_IDX_W-1:0] vec_idx;
  logic [15:0]        vector, rd_mux;

  nios_core_irq_sync #(.W(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (irq_in),
    .s       (s),
    .rise    (rise)
  );

  assign wr     = bus.chipselect & ~bus.write_n;
  assign wd     = bus.writedata[NUM_IRQ-1:0];
  assign w1c    = (wr && bus.address == ADDR_PENDING) ? wd : '0;
  assign swtrig = (wr && bus.address == ADDR_SWTRIG)  ? wd : '0;
  assign active = pending & enable;

  // Mask register: direct write, set and clear live at separate addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_ENABLE: enable <= wd;
        ADDR_ENSET:  enable <= enable | wd;
        ADDR_ENCLR:  enable <= enable & ~wd;
        default:     enable <= enable;
      endcase
    end
  end

  // Capture mode register (1 = rising edge, 0 = level).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode <= '0;
    end else if (wr && bus.address == ADDR_MODE) begin
      mode <= wd;
    end
  end

  // Pending: level bits track s; edge bits latch rise/swtrig with set winning over W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (mode & ((pending & ~w1c) | rise | swtrig)) | (~mode & s);
    end
  end

  // Lowest-index active source wins the vector.
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = i[VECTOR_IDX_W-1:0];
    end
    vector = '0;
    if (|active) begin
      vector[VECTOR_VALID_BIT]     = 1'b1;
      vector[VECTOR_IDX_W-1:0]     = vec_idx;
    end
  end

  // Read mux; unimplemented source bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_STATUS:  rd_mux = 16'(s);
      ADDR_PENDING: rd_mux = 16'(pending);
      ADDR_ENABLE,
      ADDR_ENSET,
      ADDR_ENCLR:   rd_mux = 16'(enable);
      ADDR_MODE:    rd_mux = 16'(mode);
      ADDR_VECTOR:  rd_mux = vector;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data and interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq_out      <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      irq_out      <= |active;
    end
  end

endmodule

// File: tb/tb_nios_core_irq_ctrl.sv
// Directed bench for the interrupt aggregator with hand-computed expectations.
// Latency: drives at posedge+1, samples at posedge+1.
// Backpressure: n/a.
module tb_nios_core_irq_ctrl;
  import nios_core_irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       irq_out;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] d;

  nios_core_irq_ctrl_if bus();

  nios_core_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .bus     (bus.slave),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] v);
    bus.address    = a;
    bus.writedata  = v;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    bus.address = a;
    step(1);
    v = bus.readdata;
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    step(2);
    #1 reset_n = 1'b1;
    step(1);

    // 1: reset state
    chk("rst_irq_out", 16'(irq_out), 16'h0000);
    rd(ADDR_STATUS, d);  chk("rst_status", d, 16'h0000);
    rd(ADDR_PENDING, d); chk("rst_pending", d, 16'h0000);
    rd(ADDR_ENABLE, d);  chk("rst_enable", d, 16'h0000);
    rd(ADDR_MODE, d);    chk("rst_mode", d, 16'h0000);
    rd(ADDR_VECTOR, d);  chk("rst_vector", d, 16'h0000);
    rd(ADDR_SWTRIG, d);  chk("rst_swtrig", d, 16'h0000);

    // STATUS / level pending with everything masked
    irq_in = 8'h5A;
    step(3);
    rd(ADDR_STATUS, d);  chk("status_5a", d, 16'h005A);
    rd(ADDR_PENDING, d); chk("lvl_pend_5a", d, 16'h005A);
    chk("masked_irq_out", 16'(irq_out), 16'h0000);
    irq_in = 8'h00;
    step(3);
    rd(ADDR_PENDING, d); chk("lvl_pend_clr", d, 16'h0000);

    // SW_TRIG on level bit is ignored
    wr(ADDR_SWTRIG, 16'h0001);
    rd(ADDR_PENDING, d); chk("swtrig_level_ignored", d, 16'h0000);

    // 2: level mode, latency 4 edges each way
    wr(ADDR_ENABLE, 16'h0004);
    irq_in[2] = 1'b1;
    step(3);
    chk("lvl_rise_edge3", 16'(irq_out), 16'h0000);
    step(1);
    chk("lvl_rise_edge4", 16'(irq_out), 16'h0001);
    rd(ADDR_PENDING, d); chk("lvl_pending", d, 16'h0004);
    irq_in[2] = 1'b0;
    step(3);
    chk("lvl_fall_edge3", 16'(irq_out), 16'h0001);
    step(1);
    chk("lvl_fall_edge4", 16'(irq_out), 16'h0000);

    // 3: edge mode pulse capture and W1C acknowledge
    wr(ADDR_MODE, 16'h0001);
    wr(ADDR_ENABLE, 16'h0001);
    irq_in[0] = 1'b1;
    step(1);
    irq_in[0] = 1'b0;
    step(6);
    rd(ADDR_PENDING, d); chk("edge_pulse_pend", d, 16'h0001);
    chk("edge_pulse_irq", 16'(irq_out), 16'h0001);
    wr(ADDR_PENDING, 16'h0001);
    chk("w1c_irq_same", 16'(irq_out), 16'h0001);
    step(1);
    chk("w1c_irq_next", 16'(irq_out), 16'h0000);
    rd(ADDR_PENDING, d); chk("w1c_pend", d, 16'h0000);

    // 4: rise coincides with W1C, set wins
    wr(ADDR_MODE, 16'h0003);
    wr(ADDR_ENABLE, 16'h0002);
    wr(ADDR_SWTRIG, 16'h0002);
    irq_in[1] = 1'b1;
    step(2);
    wr(ADDR_PENDING, 16'h0002);
    rd(ADDR_PENDING, d); chk("set_beats_clr_pend", d, 16'h0002);
    chk("set_beats_clr_irq", 16'(irq_out), 16'h0001);
    wr(ADDR_PENDING, 16'h0002);
    rd(ADDR_PENDING, d); chk("plain_w1c_pend", d, 16'h0000);
    irq_in[1] = 1'b0;
    step(3);

    // 5: priority vector
    wr(ADDR_MODE, 16'h00FF);
    wr(ADDR_SWTRIG, 16'h0024);
    wr(ADDR_ENABLE, 16'h0024);
    rd(ADDR_VECTOR, d); chk("vector_2", d, 16'h8002);
    wr(ADDR_ENCLR, 16'h0004);
    rd(ADDR_VECTOR, d); chk("vector_5", d, 16'h8005);
    wr(ADDR_ENCLR, 16'h0020);
    rd(ADDR_VECTOR, d); chk("vector_none", d, 16'h0000);
    chk("vector_none_irq", 16'(irq_out), 16'h0000);

    // back-to-back set/clear apply in order
    wr(ADDR_ENSET, 16'h0003);
    wr(ADDR_ENSET, 16'h0010);
    wr(ADDR_ENCLR, 16'h0001);
    rd(ADDR_ENSET, d); chk("enset_enclr_seq", d, 16'h0012);

    // 6: width masking and async reset
    wr(ADDR_ENABLE, 16'hFFFF);
    rd(ADDR_ENABLE, d); chk("enable_width", d, 16'h00FF);
    step(1);
    chk("pre_reset_irq", 16'(irq_out), 16'h0001);
    rd(ADDR_PENDING, d); chk("pre_reset_pend", d, 16'h0024);
    reset_n = 1'b0;
    #1;
    chk("async_rst_irq", 16'(irq_out), 16'h0000);
    chk("async_rst_rdata", bus.readdata, 16'h0000);
    step(1);
    reset_n = 1'b1;
    rd(ADDR_PENDING, d); chk("post_rst_pend", d, 16'h0000);
    rd(ADDR_ENABLE, d);  chk("post_rst_enable", d, 16'h0000);
    rd(ADDR_MODE, d);    chk("post_rst_mode", d, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_core_irq_ctrl.md
Name: nios_core_irq_ctrl

Overview:
Avalon-MM interrupt aggregator sitting directly downstream of the interval timer and the other peripheral irq outputs (audio, VGA, etc.).
- Per-source mask, level or rising-edge capture, software trigger and a lowest-index-first vector register.
- Drives the single irq line into the Nios core.
- Same 16-bit, 3-bit-address, registered-read slave style as the timer.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..15); bits at index >= NUM_IRQ read 0 and ignore writes.
SYNC_STAGES, 2, synchronizer depth on irq_in (2..3).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  source interrupt lines, active-high, possibly asynchronous
address  in  3  word register address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq_out  out  1  aggregated interrupt to CPU, registered

Behaviour:
Clock and reset: clk clock; reset_n asynchronous, active-low (already decided).

Reset values:
- readdata = 0, irq_out = 0.
- enable = 0, mode = 0 (all level).
- pending = 0, all synchronizer and edge flops = 0.

Write strobe: wr(a) = chipselect & ~write_n & (address == a).

Register map:
- 0 STATUS (RO): synchronized irq_in.
- 1 PENDING: read pending; write 1 clears the edge-mode bit, no effect on level-mode bits.
- 2 ENABLE (RW): mask.
- 3 MODE (RW): 1 = rising-edge, 0 = level.
- 4 ENABLE_SET: write-1-to-set enable; reads enable.
- 5 ENABLE_CLR: write-1-to-clear enable; reads enable.
- 6 VECTOR (RO): bit15 = any (pending & enable); bits[3:0] = lowest set index; other bits 0; reads 0x0000 when none.
- 7 SW_TRIG: write 1 sets pending on edge-mode bits, ignored on level bits; reads 0.

Reads:
- readdata <= mux(address) every clock, so one-cycle latency, independent of chipselect.
- Reads have no side effects.

Synchronization and edge detect:
- s = irq_in after SYNC_STAGES flops; s_d = s delayed one clock.
- rise = s & ~s_d.

Pending update per bit i, each clock:
- Level mode: pending[i] <= s[i].
- Edge mode: pending[i] <= (pending[i] & ~w1c[i]) | rise[i] | swtrig[i].
- Set beats clear: a rise or software trigger in the same cycle as W1C leaves the bit at 1.

MODE changes:
- Level -> edge: pending keeps its current value until cleared.
- Edge -> level: pending follows s from the next clock.

Output: irq_out <= |(pending & enable).

Latency (SYNC_STAGES = 2): irq_in high before edge 1 gives:
- s high after edge 2
- pending after edge 3
- irq_out after edge 4

Mask and acknowledge latency:
- ENABLE, ENABLE_SET and ENABLE_CLR take effect on enable at the write edge.
- irq_out reflects the change one clock later.
- A W1C of the last pending bit drops irq_out one clock after the write edge.

Pulse capture:
- Edge mode captures any irq_in pulse lasting at least one clk period.
- Level mode may miss pulses that deassert before the CPU reads.

Writes to ENABLE_SET and ENABLE_CLR in consecutive cycles apply in order. No write can hit both, since they are separate addresses.

Reset asserted mid-operation returns every flop to its reset value immediately. A pending edge event is lost.

Decomposition:
Shared package nios_core_irq_pkg holds:
- register address constants (ADDR_STATUS .. ADDR_SWTRIG)
- VECTOR_VALID_BIT = 15
- VECTOR_IDX_W = 4

Sub-module nios_core_irq_sync: parameterised-width synchronizer chain plus s_d register, with outputs s and rise. The top level holds the registers, priority encoder and read mux.

Test Plan:
1. Reset, then read every address -> STATUS 0, PENDING 0, ENABLE 0, MODE 0, VECTOR 0x0000, irq_out 0.
2. ENABLE = 0x0004, level mode, irq_in[2] high -> irq_out high after 4th edge; PENDING reads 0x0004; irq_in low -> irq_out low 4 edges later.
3. MODE = 0x0001, ENABLE = 0x0001, 1-cycle pulse on irq_in[0] -> PENDING 0x0001 held; write PENDING 0x0001 -> irq_out low one clock after the write.
4. Edge mode bit 1, rise[1] in the same cycle as W1C 0x0002 -> PENDING stays 0x0002 and irq_out stays high.
5. MODE 0x00FF, SW_TRIG 0x0024, ENABLE 0x0024 -> VECTOR 0x8002; ENABLE_CLR 0x0004 -> VECTOR 0x8005; ENABLE_CLR 0x0020 -> VECTOR 0x0000, irq_out low.
6. NUM_IRQ = 8, write ENABLE 0xFFFF -> read 0x00FF; reset_n pulse while pending set -> PENDING 0, irq_out 0 immediately.
